priority_resolver_n: RTL

- Parametrised, clocked successor to the 8-input interrupt priority resolver.
- Takes N request lines with a mask and tracks the in-service state.
- Arbitrates with fully-nested or rotating priority and runs the two-pulse INTA acknowledge sequence.
- Supports normal EOI, specific EOI and automatic EOI (AEOI).
- Sits between the IRR/IMR register logic and the data-bus/vector driver of the interrupt controller.

---
 rtl/pic_pkg.sv | 46 ++++
 rtl/prio_rot_encoder.sv | 22 ++
 rtl/priority_resolver_n.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared FSM state, constants and rotating-priority helpers
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } pic_state_e;

  localparam int MAX_IRQ          = 32;
  localparam int DEFAULT_SPURIOUS = 7;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } prio_hit_t;

  // Scan the ring starting just above ptr; the first set bit wins.
  function automatic prio_hit_t rot_prio_find(input logic [MAX_IRQ-1:0] vec,
                                              input logic [4:0]         ptr,
                                              input int                 n);
    prio_hit_t hit;
    int        pos;
    hit = '0;
    for (int i = 1; i <= MAX_IRQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= n) pos = pos - n;
      if (i <= n && !hit.found && vec[5'(pos)]) begin
        hit.found = 1'b1;
        hit.idx   = 5'(pos);
      end
    end
    return hit;
  endfunction

  // Distance from the top of the ring; 0 is the highest priority.
  function automatic logic [4:0] prio_rank(input logic [4:0] idx,
                                           input logic [4:0] ptr,
                                           input int         n);
    int r;
    r = int'(idx) - int'(ptr) - 1;
    if (r < 0) r = r + n;
    return 5'(r);
  endfunction

endpackage

// File: rtl/prio_rot_encoder.sv
// rtl/prio_rot_encoder.sv - combinational rotate-and-find-first priority encoder
module prio_rot_encoder
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] vec_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o
);

  prio_hit_t hit;

  always_comb begin
    hit     = rot_prio_find(MAX_IRQ'(vec_i), 5'(ptr_i), N_IRQ);
    found_o = hit.found;
    idx_o   = ID_W'(hit.idx);
  end

endmodule

// File: rtl/priority_resolver_n.sv
// rtl/priority_resolver_n.sv - N-input nested/rotating interrupt priority resolver with INTA sequencing
module priority_resolver_n
  import pic_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int ID_W        = $clog2(N_IRQ),
  parameter int SPURIOUS_ID = N_IRQ - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irr_i,
  input  logic [N_IRQ-1:0] imr_i,
  input  logic             inta_n_i,
  input  logic             aeoi_en_i,
  input  logic             rotate_en_i,
  input  logic             eoi_i,
  input  logic             seoi_i,
  input  logic [ID_W-1:0]  seoi_id_i,
  output logic             int_req_o,
  output logic [N_IRQ-1:0] isr_o,
  output logic [N_IRQ-1:0] irr_clr_o,
  output logic [ID_W-1:0]  vec_id_o,
  output logic             vec_valid_o
);

  localparam logic [ID_W-1:0] SPUR_ID = ID_W'(SPURIOUS_ID);

  pic_state_e       state_q, state_d;
  logic [ID_W-1:0]  lowest_q, lowest_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  vec_id_q, vec_id_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] irr_clr_q, irr_clr_d;
  logic             int_req_q, int_req_d;
  logic             vec_valid_q, vec_valid_d;
  logic             spur_q, spur_d;
  logic             inta_q;

  logic [N_IRQ-1:0] isr_set, isr_clr;
  logic             cand_found, isr_found, cand_valid;
  logic [ID_W-1:0]  cand_idx, isr_idx;
  logic             inta_fall, inta_rise, seoi_ok;

  prio_rot_encoder #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_cand_enc (
    .vec_i   (irr_i & ~imr_i),
    .ptr_i   (lowest_q),
    .found_o (cand_found),
    .idx_o   (cand_idx)
  );

  prio_rot_encoder #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_isr_enc (
    .vec_i   (isr_q),
    .ptr_i   (lowest_q),
    .found_o (isr_found),
    .idx_o   (isr_idx)
  );

  // Fully-nested: a request only interrupts strictly lower-priority service.
  assign cand_valid = cand_found &&
                      (!isr_found ||
                       (prio_rank(5'(cand_idx), 5'(lowest_q), N_IRQ) <
                        prio_rank(5'(isr_idx), 5'(lowest_q), N_IRQ)));

  assign inta_fall = inta_q & ~inta_n_i;
  assign inta_rise = ~inta_q & inta_n_i;
  assign seoi_ok   = seoi_i && (int'(seoi_id_i) < N_IRQ);

  always_comb begin
    state_d     = state_q;
    lowest_d    = lowest_q;
    grant_d     = grant_q;
    spur_d      = spur_q;
    vec_id_d    = vec_id_q;
    vec_valid_d = vec_valid_q;
    irr_clr_d   = '0;
    isr_set     = '0;
    isr_clr     = '0;

    if (seoi_ok) begin
      isr_clr[seoi_id_i] = 1'b1;
      if (rotate_en_i) lowest_d = seoi_id_i;
    end else if (eoi_i && isr_found) begin
      isr_clr[isr_idx] = 1'b1;
      if (rotate_en_i) lowest_d = isr_idx;
    end

    unique case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d = ACK1;
          if (cand_valid) begin
            grant_d            = cand_idx;
            spur_d             = 1'b0;
            isr_set[cand_idx]  = 1'b1;
            irr_clr_d[cand_idx] = 1'b1;
            vec_id_d           = cand_idx;
          end else begin
            spur_d   = 1'b1;
            vec_id_d = SPUR_ID;
          end
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_d     = ACK2;
          vec_valid_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d     = IDLE;
          vec_valid_d = 1'b0;
          // AEOI rotation is applied last so it overrides an EOI in the same cycle.
          if (aeoi_en_i && !spur_q) begin
            isr_clr[grant_q] = 1'b1;
            if (rotate_en_i) lowest_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting wins, so an EOI can never erase the bit being granted now.
    isr_d     = (isr_q & ~isr_clr) | isr_set;
    int_req_d = (state_d == IDLE) && cand_valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lowest_q    <= ID_W'(N_IRQ - 1);
      grant_q     <= '0;
      spur_q      <= 1'b0;
      vec_id_q    <= '0;
      vec_valid_q <= 1'b0;
      isr_q       <= '0;
      irr_clr_q   <= '0;
      int_req_q   <= 1'b0;
      inta_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      lowest_q    <= lowest_d;
      grant_q     <= grant_d;
      spur_q      <= spur_d;
      vec_id_q    <= vec_id_d;
      vec_valid_q <= vec_valid_d;
      isr_q       <= isr_d;
      irr_clr_q   <= irr_clr_d;
      int_req_q   <= int_req_d;
      inta_q      <= inta_n_i;
    end
  end

  assign int_req_o   = int_req_q;
  assign isr_o       = isr_q;
  assign irr_clr_o   = irr_clr_q;
  assign vec_id_o    = vec_id_q;
  assign vec_valid_o = vec_valid_q;

endmodule
